// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: datapath widths, ALU opcodes,
// forwarding-select encoding and the pipeline control bundle.
package core_pkg;

  localparam int N    = 32;
  localparam int RA_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b101,
    ALU_SLT = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/ex_forward_unit.sv
// EX-stage operand forwarding selects: EX/MEM beats MEM/WB beats register file;
// x0 never forwards.
module ex_forward_unit #(
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic              exm_reg_write,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  output core_pkg::fwd_sel_e fwd_a,
  output core_pkg::fwd_sel_e fwd_b
);

  function automatic core_pkg::fwd_sel_e pick(
    input logic [RA_W-1:0] rs,
    input logic            exm_we,
    input logic [RA_W-1:0] exm_dst,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_dst
  );
    if (exm_we && (exm_dst != '0) && (exm_dst == rs)) return core_pkg::FWD_MEM;
    if (wb_we && (wb_dst != '0) && (wb_dst == rs))    return core_pkg::FWD_WB;
    return core_pkg::FWD_RF;
  endfunction

  assign fwd_a = pick(rs1, exm_reg_write, exm_rd, wb_reg_write, wb_rd);
  assign fwd_b = pick(rs2, exm_reg_write, exm_rd, wb_reg_write, wb_rd);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use stall detection.
// Final ALU operands are produced combinationally from the registered fields.
module id_ex_stage #(
  parameter int N    = core_pkg::N,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [N-1:0]    id_pc,
  input  logic [N-1:0]    id_rs1_data,
  input  logic [N-1:0]    id_rs2_data,
  input  logic [N-1:0]    id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_alu_a_pc,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [N-1:0]    exm_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [N-1:0]    wb_result,
  output logic            load_use_stall,
  output logic [N-1:0]    SrcA,
  output logic [N-1:0]    SrcB,
  output logic [2:0]      AluControl,
  output logic [N-1:0]    ex_store_data,
  output logic [N-1:0]    ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch
);

  typedef struct packed {
    logic           valid;
    core_pkg::ctrl_t ctrl;
    logic [N-1:0]    pc;
    logic [N-1:0]    rs1_data;
    logic [N-1:0]    rs2_data;
    logic [N-1:0]    imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            alu_a_pc;
  } id_ex_t;

  id_ex_t             id_word;
  id_ex_t             ex_q;
  core_pkg::fwd_sel_e fwd_a;
  core_pkg::fwd_sel_e fwd_b;
  logic [N-1:0]       fwd_a_data;
  logic [N-1:0]       fwd_b_data;

  // Invalid ID slots carry no side effects into EX.
  always_comb begin
    id_word             = '0;
    id_word.valid       = id_valid;
    id_word.ctrl        = id_valid ? {id_reg_write, id_mem_read, id_mem_write,
                                      id_mem_to_reg, id_branch} : '0;
    id_word.pc          = id_pc;
    id_word.rs1_data    = id_rs1_data;
    id_word.rs2_data    = id_rs2_data;
    id_word.imm         = id_imm;
    id_word.rs1         = id_rs1;
    id_word.rs2         = id_rs2;
    id_word.rd          = id_rd;
    id_word.alu_control = id_alu_control;
    id_word.alu_src     = id_alu_src;
    id_word.alu_a_pc    = id_alu_a_pc;
  end

  // Reset, flush and stall all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every field updates from pre-edge values, whatever the statement order.
    if (reset || flush || load_use_stall) ex_q <= '0;
    else                                  ex_q <= id_word;
  end

  assign load_use_stall = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rd != '0) && id_valid &&
                          ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                           (id_uses_rs2 && (id_rs2 == ex_q.rd)));

  ex_forward_unit #(.RA_W(RA_W)) u_fwd (
    .rs1          (ex_q.rs1),
    .rs2          (ex_q.rs2),
    .exm_reg_write(exm_reg_write),
    .exm_rd       (exm_rd),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    fwd_a_data = ex_q.rs1_data;
    fwd_b_data = ex_q.rs2_data;
    case (fwd_a)
      core_pkg::FWD_MEM: fwd_a_data = exm_result;
      core_pkg::FWD_WB:  fwd_a_data = wb_result;
      default:           fwd_a_data = ex_q.rs1_data;
    endcase
    case (fwd_b)
      core_pkg::FWD_MEM: fwd_b_data = exm_result;
      core_pkg::FWD_WB:  fwd_b_data = wb_result;
      default:           fwd_b_data = ex_q.rs2_data;
    endcase
  end

  assign SrcA          = ex_q.alu_a_pc ? ex_q.pc  : fwd_a_data;
  assign SrcB          = ex_q.alu_src  ? ex_q.imm : fwd_b_data;
  assign ex_store_data = fwd_b_data;
  assign AluControl    = ex_q.alu_control;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.ctrl.reg_write;
  assign ex_mem_read   = ex_q.ctrl.mem_read;
  assign ex_mem_write  = ex_q.ctrl.mem_write;
  assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign ex_branch     = ex_q.ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX-side views are queued when
// ID stimulus is driven and popped when the DUT presents them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [2:0]  id_alu_control;
  logic        id_alu_src, id_alu_a_pc;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_result;

  logic        load_use_stall;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
  logic [2:0]  AluControl;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] store;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        valid;
    logic [4:0]  ctrl;
    logic [2:0]  alu;
    logic        stall;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_alu_a_pc(id_alu_a_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .SrcA(SrcA), .SrcB(SrcB), .AluControl(AluControl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.src_a = SrcA;
    o.src_b = SrcB;
    o.store = ex_store_data;
    o.pc    = ex_pc;
    o.rd    = ex_rd;
    o.valid = ex_valid;
    o.ctrl  = {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch};
    o.alu   = AluControl;
    o.stall = load_use_stall;
    return o;
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs) return exm_result;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)    return wb_result;
    return rf;
  endfunction

  // Expected EX view once the current ID inputs are captured.
  function automatic obs_t model_capture();
    obs_t e;
    logic [31:0] fa, fb;
    fa      = model_fwd(id_rs1, id_rs1_data);
    fb      = model_fwd(id_rs2, id_rs2_data);
    e.src_a = id_alu_a_pc ? id_pc : fa;
    e.src_b = id_alu_src ? id_imm : fb;
    e.store = fb;
    e.pc    = id_pc;
    e.rd    = id_rd;
    e.valid = id_valid;
    e.ctrl  = id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} : 5'd0;
    e.alu   = id_alu_control;
    e.stall = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_alu_control = 3'b000; id_alu_src = 1'b0; id_alu_a_pc = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0; id_branch = 1'b0;
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic test_random();
    sb_item_t it;
    obs_t got;
    for (int i = 0; i < 30; i++) begin
      id_valid       = 1'($urandom_range(0, 1));
      id_pc          = $urandom;
      id_rs1_data    = $urandom;
      id_rs2_data    = $urandom;
      id_imm         = $urandom;
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_rd          = 5'($urandom);
      id_uses_rs1    = 1'($urandom_range(0, 1));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      id_alu_control = 3'($urandom);
      id_alu_src     = 1'($urandom_range(0, 1));
      id_alu_a_pc    = 1'($urandom_range(0, 1));
      id_reg_write   = 1'($urandom_range(0, 1));
      id_mem_read    = 1'b0;
      id_mem_write   = 1'($urandom_range(0, 1));
      id_mem_to_reg  = 1'($urandom_range(0, 1));
      id_branch      = 1'($urandom_range(0, 1));
      exm_reg_write  = 1'($urandom_range(0, 1));
      exm_rd         = 5'($urandom_range(0, 3));
      exm_result     = $urandom;
      wb_reg_write   = 1'($urandom_range(0, 1));
      wb_rd          = 5'($urandom_range(0, 3));
      wb_result      = $urandom;
      sb.push_back('{"random", model_capture()});
      tick();
      it = sb.pop_front(); got = observe(); n_checks++;
      if (got !== it.exp) $display("FAIL %s[%0d]: got %h expected %h", it.tag, i, got, it.exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    sb_item_t it;
    obs_t got;
    reset = 1'b1;
    id_valid = 1'b1; id_reg_write = 1'b1; id_mem_write = 1'b1; id_branch = 1'b1;
    id_alu_control = 3'b111; id_pc = 32'h1234_5678;
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hDEAD_BEEF;
    sb.push_back('{"reset_bubble", obs_t'('0)});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    sb_item_t it;
    obs_t got, e;
    idle();
    id_valid = 1'b1; id_pc = 32'h40; id_rs1 = 5'd5; id_rs2 = 5'd3; id_rd = 5'd6;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_reg_write = 1'b1;
    id_rs1_data = 32'h0BAD; id_rs2_data = 32'h4;
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'h10;
    e = model_capture(); e.src_a = 32'h10; e.src_b = 32'h4; e.store = 32'h4;
    sb.push_back('{"b2b_exmem", e});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'h22;
    #1;
    sb.push_back('{"b2b_exmem_wins", e});
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    exm_reg_write = 1'b0;
    #1;
    e.src_a = 32'h22;
    sb.push_back('{"b2b_memwb", e});
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;
  endtask

  task automatic test_x0_guard();
    sb_item_t it;
    obs_t got, e;
    idle();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd4; id_reg_write = 1'b1;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_pc = 32'h60;
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hDEAD;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hBEEF;
    e = model_capture(); e.src_a = 32'h0; e.src_b = 32'h0; e.store = 32'h0;
    sb.push_back('{"x0_guard", e});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;
  endtask

  task automatic drive_load_x7();
    idle();
    id_valid = 1'b1; id_pc = 32'h80; id_rs1 = 5'd1; id_uses_rs1 = 1'b1; id_rd = 5'd7;
    id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
    id_alu_src = 1'b1; id_imm = 32'h4; id_rs1_data = 32'h1000;
  endtask

  task automatic test_load_use();
    sb_item_t it;
    obs_t got, e;
    drive_load_x7();
    sb.push_back('{"lu_load_in_ex", model_capture()});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    // add x8, x7, x1 arrives in ID behind the load
    id_pc = 32'h84; id_rs1 = 5'd7; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_rd = 5'd8; id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_to_reg = 1'b0;
    id_alu_src = 1'b0; id_imm = '0; id_rs1_data = 32'h0; id_rs2_data = 32'h1000;
    #1;
    n_checks++;
    if (load_use_stall !== 1'b1) $display("FAIL lu_stall_asserted: got %b expected 1", load_use_stall);
    else n_pass++;

    exm_reg_write = 1'b1; exm_rd = 5'd7; exm_result = 32'h1004;
    sb.push_back('{"lu_bubble", obs_t'('0)});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = '0;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'h1234;
    e = model_capture(); e.src_a = 32'h1234;
    sb.push_back('{"lu_add_captured", e});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    // lui x8 behind a load to x7: rs1 field matches but is not read
    drive_load_x7();
    tick();
    id_pc = 32'h88; id_rs1 = 5'd7; id_rs2 = 5'd7; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rd = 5'd8; id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_imm = 32'h1234_5000;
    #1;
    n_checks++;
    if (load_use_stall !== 1'b0) $display("FAIL lu_no_stall_lui: got %b expected 0", load_use_stall);
    else n_pass++;
    sb.push_back('{"lu_lui_captured", model_capture()});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    // load to x0 never stalls a reader of x0
    drive_load_x7();
    id_rd = 5'd0;
    tick();
    id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rd = 5'd9; id_mem_read = 1'b0;
    #1;
    n_checks++;
    if (load_use_stall !== 1'b0) $display("FAIL lu_rd0_no_stall: got %b expected 0", load_use_stall);
    else n_pass++;
  endtask

  task automatic test_flush();
    sb_item_t it;
    obs_t got;
    drive_load_x7();
    tick();
    // sw x7, 8(x2) depends on the load through rs2 while a redirect flushes
    id_pc = 32'h90; id_rs1 = 5'd2; id_rs2 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_to_reg = 1'b0;
    id_mem_write = 1'b1; id_imm = 32'h8;
    flush = 1'b1;
    #1;
    n_checks++;
    if (load_use_stall !== 1'b1) $display("FAIL flush_stall_asserted: got %b expected 1", load_use_stall);
    else n_pass++;
    sb.push_back('{"flush_stall_bubble", obs_t'('0)});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    id_pc = 32'h200; id_rs2 = 5'd3;
    sb.push_back('{"flush_only_bubble", obs_t'('0)});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;
    flush = 1'b0;
  endtask

  task automatic test_imm_pc();
    sb_item_t it;
    obs_t got, e;
    idle();
    id_valid = 1'b1; id_alu_a_pc = 1'b1; id_pc = 32'h100; id_alu_src = 1'b1;
    id_imm = 32'hFFFF_F800; id_rs1 = 5'd4; id_rs1_data = 32'h999; id_rs2 = 5'd9;
    id_rs2_data = 32'h55; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_mem_write = 1'b1;
    id_alu_control = 3'b110;
    exm_reg_write = 1'b1; exm_rd = 5'd9; exm_result = 32'h77;
    e = model_capture(); e.src_a = 32'h100; e.src_b = 32'hFFFF_F800; e.store = 32'h77;
    sb.push_back('{"imm_pc_mux", e});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;

    id_valid = 1'b0; id_reg_write = 1'b1; id_branch = 1'b1; id_pc = 32'h300;
    id_alu_control = 3'b111;
    e = model_capture(); e.ctrl = 5'd0; e.valid = 1'b0;
    sb.push_back('{"invalid_ctrl_zero", e});
    tick();
    it = sb.pop_front(); got = observe(); n_checks++;
    if (got !== it.exp) $display("FAIL %s: got %h expected %h", it.tag, got, it.exp);
    else n_pass++;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    test_random();
    test_reset();
    test_back_to_back();
    test_x0_guard();
    test_load_use();
    test_flush();
    test_imm_pc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
